// File: rtl/bt_cmd_rx.sv
// UART 8N1 receiver with drive-command decoder for the Bluetooth-controlled car.
// Define BT_WATCHDOG_EN to add a link-loss watchdog that forces stop in manual mode.
module bt_cmd_rx #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int WDOG_CYC = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic [2:0] cmd_dir,
  output logic       manual_en,
  output logic [7:0] seg_code,
  output logic       wdog_trip
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  if (CLKS_PER_BIT < 4 || WDOG_CYC < 2) begin : g_bad_cfg
    $error("bt_cmd_rx: CLK_HZ/BAUD must be >= 4 and WDOG_CYC >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               sync1_q, sync2_q;
  logic [7:0]         byte_data_q, byte_data_d;
  logic               byte_valid_q, byte_valid_d;
  logic               frame_err_q, frame_err_d;
  logic [2:0]         cmd_dir_q, cmd_dir_d;
  logic               manual_en_q, manual_en_d;
  logic [7:0]         seg_code_q, seg_code_d;
  logic               wdog_trip_q, wdog_trip_d;
  logic               rx_s;

`ifdef BT_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC);
  logic [WD_W-1:0]    wcnt_q, wcnt_d;
`endif

  assign rx_s = sync2_q;

  function automatic logic [7:0] seg_of(input logic [7:0] b);
    logic [7:0] s;
    case (b)
      8'h00:   s = 8'hC0;
      8'h01:   s = 8'hF9;
      8'h02:   s = 8'hA4;
      8'h03:   s = 8'hB0;
      8'h04:   s = 8'h99;
      8'h05:   s = 8'h92;
      8'h06:   s = 8'h82;
      8'h07:   s = 8'hF8;
      8'h08:   s = 8'h80;
      8'h09:   s = 8'h90;
      default: s = 8'hBF;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    cmd_dir_d    = cmd_dir_q;
    manual_en_d  = manual_en_q;
    seg_code_d   = seg_code_q;
    wdog_trip_d  = wdog_trip_q;
`ifdef BT_WATCHDOG_EN
    wcnt_d       = wcnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          // a start bit that is already high again at mid-bit is a glitch
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d      = S_IDLE;
            byte_valid_d = 1'b1;
            byte_data_d  = shift_q;
            seg_code_d   = seg_of(shift_q);
            case (shift_q)
              8'h00:   cmd_dir_d   = 3'b010;
              8'h01:   cmd_dir_d   = 3'b111;
              8'h02:   cmd_dir_d   = 3'b011;
              8'h03:   cmd_dir_d   = 3'b100;
              8'h04:   cmd_dir_d   = 3'b001;
              8'h05:   manual_en_d = 1'b1;
              8'h06:   manual_en_d = 1'b0;
              default: cmd_dir_d   = cmd_dir_q;
            endcase
          end else begin
            state_d     = S_WAIT_HIGH;
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_HIGH: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (rx_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_HIGH;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef BT_WATCHDOG_EN
    // a fresh byte always wins over the timeout and is decoded as usual
    if (byte_valid_d) begin
      wcnt_d      = '0;
      wdog_trip_d = 1'b0;
    end else if (!manual_en_q) begin
      wcnt_d = '0;
    end else if (wcnt_q == WD_W'(WDOG_CYC - 1)) begin
      wdog_trip_d = 1'b1;
      cmd_dir_d   = 3'b001;
    end else begin
      wcnt_d = wcnt_q + WD_W'(1);
    end
`else
    wdog_trip_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      byte_data_q  <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      cmd_dir_q    <= 3'b001;
      manual_en_q  <= 1'b0;
      seg_code_q   <= 8'h8C;
      wdog_trip_q  <= 1'b0;
`ifdef BT_WATCHDOG_EN
      wcnt_q       <= '0;
`endif
    end else begin
      sync1_q      <= rx;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      cmd_dir_q    <= cmd_dir_d;
      manual_en_q  <= manual_en_d;
      seg_code_q   <= seg_code_d;
      wdog_trip_q  <= wdog_trip_d;
`ifdef BT_WATCHDOG_EN
      wcnt_q       <= wcnt_d;
`endif
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;
  assign cmd_dir    = cmd_dir_q;
  assign manual_en  = manual_en_q;
  assign seg_code   = seg_code_q;
  assign wdog_trip  = wdog_trip_q;
endmodule

// File: tb/tb_bt_cmd_rx.sv
// Directed bench for bt_cmd_rx at 10 clocks per bit (CLK_HZ=1 MHz, BAUD=100 kHz).
module tb_bt_cmd_rx;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_err;
  logic [2:0] cmd_dir;
  logic       manual_en;
  logic [7:0] seg_code;
  logic       wdog_trip;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_bv_cyc = 0;
  int bv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;

  bt_cmd_rx #(.CLK_HZ(1_000_000), .BAUD(100_000), .WDOG_CYC(500)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .byte_data(byte_data), .byte_valid(byte_valid), .frame_err(frame_err),
    .cmd_dir(cmd_dir), .manual_en(manual_en), .seg_code(seg_code),
    .wdog_trip(wdog_trip)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // strobe monitor: counts high cycles, so a stretched pulse shows up as an extra count
  always @(negedge clk) begin
    if (rst_n && byte_valid) begin
      bv_cnt      <= bv_cnt + 1;
      last_bv_cyc <= cyc;
    end
    if (rst_n && frame_err) fe_cnt <= fe_cnt + 1;
    if (byte_valid && frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // one 8N1 frame; stop_low>0 holds the stop bit low for that many cycles
  task automatic send_byte(input logic [7:0] b, input int stop_low);
    @(negedge clk);
    start_cyc = cyc;
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) @(negedge clk);
    end
    if (stop_low > 0) begin
      rx = 1'b0;
      repeat (stop_low) @(negedge clk);
      rx = 1'b1;
    end
    rx = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_cmd", 32'(cmd_dir), 32'h1);
    chk("rst_man", 32'(manual_en), 32'h0);
    chk("rst_seg", 32'(seg_code), 32'h8C);
    chk("rst_data", 32'(byte_data), 32'h00);
    chk("rst_bv", 32'(byte_valid), 32'h0);
    chk("rst_wd", 32'(wdog_trip), 32'h0);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("idle_bv", 32'(bv_cnt), 32'd0);
    chk("idle_fe", 32'(fe_cnt), 32'd0);
    chk("idle_cmd", 32'(cmd_dir), 32'h1);
    chk("idle_seg", 32'(seg_code), 32'h8C);

    send_byte(8'h05, 0);
    chk("lat05", 32'(last_bv_cyc - start_cyc), 32'd98);
    chk("man05", 32'(manual_en), 32'h1);
    chk("seg05", 32'(seg_code), 32'h92);
    chk("cmd05", 32'(cmd_dir), 32'h1);
    send_byte(8'h00, 0);
    chk("lat00", 32'(last_bv_cyc - start_cyc), 32'd98);
    chk("cmd00", 32'(cmd_dir), 32'h2);
    chk("seg00", 32'(seg_code), 32'hC0);
    chk("data00", 32'(byte_data), 32'h00);
    chk("man00", 32'(manual_en), 32'h1);
    chk("bv2", 32'(bv_cnt), 32'd2);

    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_bv", 32'(bv_cnt), 32'd2);
    chk("glitch_fe", 32'(fe_cnt), 32'd0);
    send_byte(8'h03, 0);
    chk("cmd03", 32'(cmd_dir), 32'h4);
    chk("seg03", 32'(seg_code), 32'hB0);
    chk("bv3", 32'(bv_cnt), 32'd3);

    send_byte(8'h02, 30);
    chk("ferr_cnt", 32'(fe_cnt), 32'd1);
    chk("ferr_bv", 32'(bv_cnt), 32'd3);
    chk("ferr_cmd", 32'(cmd_dir), 32'h4);
    chk("ferr_data", 32'(byte_data), 32'h03);
    chk("ferr_seg", 32'(seg_code), 32'hB0);
    send_byte(8'h01, 0);
    chk("cmd01", 32'(cmd_dir), 32'h7);
    chk("seg01", 32'(seg_code), 32'hF9);
    chk("data01", 32'(byte_data), 32'h01);

    send_byte(8'h41, 0);
    chk("data41", 32'(byte_data), 32'h41);
    chk("seg41", 32'(seg_code), 32'hBF);
    chk("cmd41", 32'(cmd_dir), 32'h7);
    chk("man41", 32'(manual_en), 32'h1);
    chk("bv5", 32'(bv_cnt), 32'd5);

    send_byte(8'h00, 0);
    chk("wd_cmd0", 32'(cmd_dir), 32'h2);
`ifdef BT_WATCHDOG_EN
    while (cyc < last_bv_cyc + 499) @(negedge clk);
    chk("wd_pre", 32'(wdog_trip), 32'h0);
    chk("wd_pre_cmd", 32'(cmd_dir), 32'h2);
    @(negedge clk);
    chk("wd_trip", 32'(wdog_trip), 32'h1);
    chk("wd_cmd", 32'(cmd_dir), 32'h1);
    send_byte(8'h01, 0);
    chk("wd_clr", 32'(wdog_trip), 32'h0);
    chk("wd_cmd01", 32'(cmd_dir), 32'h7);
`else
    repeat (600) @(negedge clk);
    chk("nowd_trip", 32'(wdog_trip), 32'h0);
    chk("nowd_cmd", 32'(cmd_dir), 32'h2);
`endif
    chk("overlap", 32'(both_cnt), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
